// File: rtl/toy_pack.sv
// Shared core-wide constants for the toy core.
package toy_pack;
   parameter int REG_WIDTH = 64;
endpackage

// File: rtl/toy_phy_rf_wb_arbiter_if.sv
// Writeback bundle: per-source result handshake in, per-entry regfile write and wakeup out.
// Perf counter signals exist only when TOY_WB_ARB_PERF_EN is defined.
interface toy_phy_rf_wb_arbiter_if #(
   parameter int NUM_SRC     = 4,
   parameter int NUM_WR_PORT = 2,
   parameter int PHY_REG_NUM = 96,
   parameter int REG_WIDTH   = toy_pack::REG_WIDTH
);
   localparam int ID_W = $clog2(PHY_REG_NUM);

   logic [NUM_SRC-1:0]                    src_vld;
   logic [NUM_SRC-1:0]                    src_rdy;
   logic [NUM_SRC-1:0][ID_W-1:0]          src_phy_id;
   logic [NUM_SRC-1:0][REG_WIDTH-1:0]     src_data;
   logic [PHY_REG_NUM-1:0]                wr_en;
   logic [PHY_REG_NUM-1:0][REG_WIDTH-1:0] wr_reg_data;
   logic [NUM_WR_PORT-1:0]                wkup_vld;
   logic [NUM_WR_PORT-1:0][ID_W-1:0]      wkup_phy_id;
   logic                                  err_dup_wr;
`ifdef TOY_WB_ARB_PERF_EN
   logic [31:0]                           perf_stall_cnt;
   logic [31:0]                           perf_wr_cnt;

   modport master (
      output src_vld, src_phy_id, src_data,
      input  src_rdy, wr_en, wr_reg_data, wkup_vld, wkup_phy_id, err_dup_wr,
      input  perf_stall_cnt, perf_wr_cnt
   );
   modport slave (
      input  src_vld, src_phy_id, src_data,
      output src_rdy, wr_en, wr_reg_data, wkup_vld, wkup_phy_id, err_dup_wr,
      output perf_stall_cnt, perf_wr_cnt
   );
`else
   modport master (
      output src_vld, src_phy_id, src_data,
      input  src_rdy, wr_en, wr_reg_data, wkup_vld, wkup_phy_id, err_dup_wr
   );
   modport slave (
      input  src_vld, src_phy_id, src_data,
      output src_rdy, wr_en, wr_reg_data, wkup_vld, wkup_phy_id, err_dup_wr
   );
`endif
endinterface

// File: rtl/toy_phy_rf_wb_arbiter.sv
// Per-source writeback FIFOs, round-robin grant of up to NUM_WR_PORT heads, registered regfile write decode
// (accept->wr_en 2 cycles, src_rdy = registered not-full); TOY_WB_ARB_PERF_EN adds stall/write counters.
module toy_phy_rf_wb_arbiter #(
   parameter int NUM_SRC     = 4,
   parameter int NUM_WR_PORT = 2,
   parameter int PHY_REG_NUM = 96,
   parameter int FIFO_DEPTH  = 2,
   parameter int MODE        = 0,
   parameter int REG_WIDTH   = toy_pack::REG_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   toy_phy_rf_wb_arbiter_if.slave   wb
);

   localparam int ID_W  = $clog2(PHY_REG_NUM);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [REG_WIDTH-1:0] data;
   } wb_ent_t;

   wb_ent_t                          fifo_mem [NUM_SRC][FIFO_DEPTH];
   wb_ent_t                          head     [NUM_SRC];
   logic [PTR_W-1:0]                 wptr_q   [NUM_SRC];
   logic [PTR_W-1:0]                 rptr_q   [NUM_SRC];
   logic [CNT_W-1:0]                 cnt_q    [NUM_SRC];
   logic [CNT_W-1:0]                 cnt_nxt  [NUM_SRC];
   logic [NUM_SRC-1:0]               rdy_q;
   logic [NUM_SRC-1:0]               push;
   logic [NUM_SRC-1:0]               pop;
   logic [NUM_SRC-1:0]               nonempty;
   logic [NUM_SRC-1:0]               ne_rot;
   logic [NUM_SRC-1:0]               pop_rot;
   logic [SRC_W-1:0]                 rr_ptr_q;
   logic [SRC_W-1:0]                 rr_ptr_nxt;

   logic [NUM_WR_PORT-1:0]           gnt_vld;
   logic [NUM_WR_PORT-1:0][SRC_W-1:0] gnt_src;
   logic [NUM_WR_PORT-1:0]           port_wr;
   logic [NUM_WR_PORT-1:0][ID_W-1:0] port_id;
   logic [NUM_WR_PORT-1:0][REG_WIDTH-1:0] port_data;
   logic                             dup_hit;
   logic [PHY_REG_NUM-1:0]           wr_en_nxt;

   logic [PHY_REG_NUM-1:0]                wr_en_q;
   logic [PHY_REG_NUM-1:0][REG_WIDTH-1:0] wr_reg_data_q;
   logic [NUM_WR_PORT-1:0]                wkup_vld_q;
   logic [NUM_WR_PORT-1:0][ID_W-1:0]      wkup_phy_id_q;
   logic                                  err_dup_wr_q;

   assign push       = wb.src_vld & rdy_q;
   assign wb.src_rdy = rdy_q;

   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         nonempty[s] = (cnt_q[s] != '0);
         head[s]     = fifo_mem[s][rptr_q[s]];
         cnt_nxt[s]  = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
   end

   // Rotate so that bit 0 is the source at rr_ptr; the scan then runs in plain index order.
   always_comb begin
      int n;
      int idx;
      ne_rot     = NUM_SRC'({nonempty, nonempty} >> rr_ptr_q);
      pop_rot    = '0;
      gnt_vld    = '0;
      gnt_src    = '0;
      rr_ptr_nxt = rr_ptr_q;
      n          = 0;
      idx        = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (ne_rot[i] && n < NUM_WR_PORT) begin
            pop_rot[i] = 1'b1;
            for (int p = 0; p < NUM_WR_PORT; p++) begin
               if (n == p) begin
                  gnt_vld[p] = 1'b1;
                  gnt_src[p] = SRC_W'(idx);
               end
            end
            rr_ptr_nxt = (idx == NUM_SRC - 1) ? '0 : SRC_W'(idx + 1);
            n          = n + 1;
         end
      end
   end

   assign pop = NUM_SRC'(({pop_rot, pop_rot} << rr_ptr_q) >> NUM_SRC);

   // Lower port wins on a duplicate id; the later port's write and wakeup are dropped.
   always_comb begin
      dup_hit   = 1'b0;
      port_wr   = '0;
      port_id   = '0;
      port_data = '0;
      for (int p = 0; p < NUM_WR_PORT; p++) begin
         port_id[p]   = head[gnt_src[p]].id;
         port_data[p] = head[gnt_src[p]].data;
         port_wr[p]   = gnt_vld[p];
         if (MODE == 0 && port_id[p] == '0) port_wr[p] = 1'b0;
         for (int q = 0; q < p; q++) begin
            if (port_wr[q] && port_wr[p] && port_id[q] == port_id[p]) begin
               port_wr[p] = 1'b0;
               dup_hit    = 1'b1;
            end
         end
      end
      wr_en_nxt = '0;
      for (int e = 0; e < PHY_REG_NUM; e++) begin
         for (int p = 0; p < NUM_WR_PORT; p++) begin
            if (port_wr[p] && port_id[p] == ID_W'(e)) wr_en_nxt[e] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < NUM_SRC; s++) begin
         if (push[s]) fifo_mem[s][wptr_q[s]] <= '{id: wb.src_phy_id[s], data: wb.src_data[s]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            wptr_q[s] <= '0;
            rptr_q[s] <= '0;
            cnt_q[s]  <= '0;
         end
         rdy_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) wptr_q[s] <= wptr_q[s] + 1'b1;
            if (pop[s])  rptr_q[s] <= rptr_q[s] + 1'b1;
            cnt_q[s] <= cnt_nxt[s];
            rdy_q[s] <= (cnt_nxt[s] != CNT_W'(FIFO_DEPTH));
         end
         rr_ptr_q <= rr_ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en_q       <= '0;
         wr_reg_data_q <= '0;
         wkup_vld_q    <= '0;
         wkup_phy_id_q <= '0;
         err_dup_wr_q  <= 1'b0;
      end else begin
         wr_en_q <= wr_en_nxt;
         for (int p = 0; p < NUM_WR_PORT; p++) begin
            if (port_wr[p]) wr_reg_data_q[port_id[p]] <= port_data[p];
            wkup_phy_id_q[p] <= port_wr[p] ? port_id[p] : '0;
         end
         wkup_vld_q   <= port_wr;
         err_dup_wr_q <= err_dup_wr_q | dup_hit;
      end
   end

   assign wb.wr_en       = wr_en_q;
   assign wb.wr_reg_data = wr_reg_data_q;
   assign wb.wkup_vld    = wkup_vld_q;
   assign wb.wkup_phy_id = wkup_phy_id_q;
   assign wb.err_dup_wr  = err_dup_wr_q;

`ifdef TOY_WB_ARB_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_wr_q;
   logic [32:0] perf_wr_sum;
   logic [32:0] perf_stall_sum;

   always_comb begin
      int nwr;
      nwr = 0;
      for (int p = 0; p < NUM_WR_PORT; p++) begin
         if (port_wr[p]) nwr = nwr + 1;
      end
      perf_wr_sum    = {1'b0, perf_wr_q} + 33'(nwr);
      perf_stall_sum = {1'b0, perf_stall_q} + 33'(|(nonempty & ~pop));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_wr_q    <= '0;
      end else begin
         perf_stall_q <= perf_stall_sum[32] ? '1 : perf_stall_sum[31:0];
         perf_wr_q    <= perf_wr_sum[32]    ? '1 : perf_wr_sum[31:0];
      end
   end

   assign wb.perf_stall_cnt = perf_stall_q;
   assign wb.perf_wr_cnt    = perf_wr_q;
`endif

endmodule

// File: tb/tb_toy_phy_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter: single-write table plus duplicate, throughput and reset sequences.
module tb_toy_phy_rf_wb_arbiter;

   localparam int NS  = 4;
   localparam int NP  = 2;
   localparam int NR  = 96;
   localparam int RW  = toy_pack::REG_WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   toy_phy_rf_wb_arbiter_if #(.NUM_SRC(NS), .NUM_WR_PORT(NP), .PHY_REG_NUM(NR)) wb ();

   toy_phy_rf_wb_arbiter #(
      .NUM_SRC(NS), .NUM_WR_PORT(NP), .PHY_REG_NUM(NR), .FIFO_DEPTH(2), .MODE(0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb)
   );

   typedef struct {
      int          src;
      int          id;
      logic [RW-1:0] data;
      bit          exp_wr;
   } vec_t;

   vec_t          vecs [5];
   logic [RW-1:0] exp_q [NS][$];
   int            seq [NS];
   int            n_chk  = 0;
   int            n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_src();
      wb.src_vld    = '0;
      wb.src_phy_id = '0;
      wb.src_data   = '0;
   endtask

   function automatic logic [NR-1:0] onehot(input int id);
      return NR'(1) << id;
   endfunction

   task automatic drive_src(input int s, input int id, input logic [RW-1:0] d);
      wb.src_vld[s]    = 1'b1;
      wb.src_phy_id[s] = 7'(id);
      wb.src_data[s]   = d;
   endtask

   task automatic send_one(input vec_t v);
      chk("rdy_before_push", 128'((wb.src_rdy >> v.src) & 4'h1), 128'h1);
      drive_src(v.src, v.id, v.data);
      step();
      idle_src();
      chk("no_wr_first_cycle", 128'(wb.wr_en), 128'h0);
      step();
      if (v.exp_wr) begin
         chk("wr_en_onehot", 128'(wb.wr_en), 128'(onehot(v.id)));
         chk("wr_data", 128'(wb.wr_reg_data[v.id]), 128'(v.data));
         chk("wkup_vld", 128'(wb.wkup_vld), 128'h1);
         chk("wkup_id", 128'(wb.wkup_phy_id[0]), 128'(v.id));
      end else begin
         chk("id0_no_wr", 128'(wb.wr_en), 128'h0);
         chk("id0_no_wkup", 128'(wb.wkup_vld), 128'h0);
      end
      step();
      chk("wr_en_one_cycle", 128'(wb.wr_en), 128'h0);
      chk("wkup_one_cycle", 128'(wb.wkup_vld), 128'h0);
      if (v.exp_wr) chk("wr_data_held", 128'(wb.wr_reg_data[v.id]), 128'(v.data));
   endtask

   task automatic sb_check();
      for (int p = 0; p < NP; p++) begin
         if (wb.wkup_vld[p]) begin
            int id;
            int s;
            id = int'(wb.wkup_phy_id[p]);
            s  = id - 10;
            if (s < 0 || s >= NS) begin
               chk("sb_id_range", 128'(id), 128'(10));
            end else if (exp_q[s].size() == 0) begin
               chk("sb_unexpected_wkup", 128'(id), 128'h0);
            end else begin
               chk("sb_data_order", 128'(wb.wr_reg_data[id]), 128'(exp_q[s].pop_front()));
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{src: 0, id: 5,  data: 'hA5,   exp_wr: 1'b1};
      vecs[1] = '{src: 2, id: 0,  data: 'h55,   exp_wr: 1'b0};
      vecs[2] = '{src: 2, id: 7,  data: 'h77,   exp_wr: 1'b1};
      vecs[3] = '{src: 3, id: 95, data: 'hDEAD, exp_wr: 1'b1};
      vecs[4] = '{src: 1, id: 1,  data: 'h1234, exp_wr: 1'b1};

      idle_src();
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_src_rdy", 128'(wb.src_rdy), 128'h0);
      chk("rst_wr_en", 128'(wb.wr_en), 128'h0);
      chk("rst_wkup_vld", 128'(wb.wkup_vld), 128'h0);
      chk("rst_err", 128'(wb.err_dup_wr), 128'h0);
      chk("rst_wr_data_zero", 128'(wb.wr_reg_data == '0), 128'h1);
      rst_n = 1'b1;
      step();
      chk("rdy_after_release", 128'(wb.src_rdy), 128'hF);

      for (int i = 0; i < 5; i++) send_one(vecs[i]);
      chk("err_clear_before_dup", 128'(wb.err_dup_wr), 128'h0);

      // rr_ptr now points at source 2, so source 0 lands on port 0.
      drive_src(0, 20, 'h11);
      drive_src(1, 20, 'h22);
      step();
      idle_src();
      step();
      chk("dup_wr_en", 128'(wb.wr_en), 128'(onehot(20)));
      chk("dup_data_port0", 128'(wb.wr_reg_data[20]), 128'h11);
      chk("dup_wkup_vld", 128'(wb.wkup_vld), 128'h1);
      chk("dup_wkup_id", 128'(wb.wkup_phy_id[0]), 128'd20);
      chk("dup_err_set", 128'(wb.err_dup_wr), 128'h1);
      step();
      chk("dup_err_sticky", 128'(wb.err_dup_wr), 128'h1);
      chk("dup_data_kept", 128'(wb.wr_reg_data[20]), 128'h11);
      chk("dup_wr_en_clear", 128'(wb.wr_en), 128'h0);

      // Saturated throughput: pairs alternate {2,3},{0,1} starting from rr_ptr=2.
      for (int s = 0; s < NS; s++) seq[s] = 0;
      for (int c = 0; c < 14; c++) begin
         logic [NS-1:0] fire;
         for (int s = 0; s < NS; s++) drive_src(s, 10 + s, RW'(s * 256 + seq[s]));
         fire = wb.src_rdy;
         for (int s = 0; s < NS; s++) begin
            if (fire[s]) begin
               exp_q[s].push_back(RW'(s * 256 + seq[s]));
               seq[s]++;
            end
         end
         step();
         if (c == 0) begin
            chk("tp_first_no_wkup", 128'(wb.wkup_vld), 128'h0);
         end else begin
            chk("tp_wkup_both", 128'(wb.wkup_vld), 128'h3);
            chk("tp_port0_id", 128'(wb.wkup_phy_id[0]), (c % 2 == 1) ? 128'd12 : 128'd10);
            chk("tp_port1_id", 128'(wb.wkup_phy_id[1]), (c % 2 == 1) ? 128'd13 : 128'd11);
            chk("tp_src_rdy", 128'(wb.src_rdy), (c % 2 == 1) ? 128'hC : 128'h3);
         end
         sb_check();
      end
      idle_src();
      for (int c = 0; c < 6; c++) begin
         step();
         sb_check();
      end
      for (int s = 0; s < NS; s++) chk("tp_drained", 128'(exp_q[s].size()), 128'h0);
      chk("tp_rdy_idle", 128'(wb.src_rdy), 128'hF);

      // Reset with three entries buffered: all are discarded.
      drive_src(0, 30, 'h30);
      drive_src(1, 31, 'h31);
      drive_src(2, 32, 'h32);
      step();
      idle_src();
      rst_n = 1'b0;
      step();
      chk("mid_rst_wr_en", 128'(wb.wr_en), 128'h0);
      chk("mid_rst_wkup", 128'(wb.wkup_vld), 128'h0);
      chk("mid_rst_err", 128'(wb.err_dup_wr), 128'h0);
      chk("mid_rst_rdy", 128'(wb.src_rdy), 128'h0);
      chk("mid_rst_data", 128'(wb.wr_reg_data == '0), 128'h1);
      rst_n = 1'b1;
      step();
      chk("post_rst_rdy", 128'(wb.src_rdy), 128'hF);
      chk("post_rst_no_wr", 128'(wb.wr_en), 128'h0);
      step();
      chk("post_rst_discard_wr", 128'(wb.wr_en), 128'h0);
      chk("post_rst_discard_wkup", 128'(wb.wkup_vld), 128'h0);
      send_one('{src: 0, id: 9, data: 'h99, exp_wr: 1'b1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
